add_sub_serial: RTL and testbench
=================================

ADD_SUB_SERIAL -- requirements
Module: add_sub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, 2..64.
REQ-002 SHALL have parameter DIGIT, default 1: bits processed per cycle; WIDTH is an integer multiple of DIGIT.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request to begin an operation.
REQ-006 SHALL have port a, input, WIDTH: operand A.
REQ-007 SHALL have port b, input, WIDTH: operand B.
REQ-008 SHALL have port c_in, input, 1: mode select, 0 = A+B, 1 = A-B (two's complement: B inverted, carry-in 1).
REQ-009 SHALL have port busy, output, 1: operation in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pulse marking a valid result.
REQ-011 SHALL have port sum, output, WIDTH: result register.
REQ-012 SHALL have port c_out, output, 1: final carry; for subtract, 1 = no borrow.
REQ-013 SHALL have port overflow, output, 1: signed overflow flag (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: busy=0, done=0; start=1 -> capture a, b XOR {WIDTH{c_in}}, carry=c_in, step count=0, go to RUN.
REQ-016 RUN: busy=1; each cycle add the low DIGIT bits of the operand shift registers plus the carry, shift the partial result in from the MSB side, update the carry, increment the step count.
REQ-017 RUN: on step WIDTH/DIGIT-1, go to DONE; RUN occupies exactly WIDTH/DIGIT cycles.
REQ-018 DONE: done=1 and busy=0 for exactly one cycle; sum, c_out and overflow load in the same edge that enters DONE.
REQ-019 DONE: start=1 -> capture new operands and go to RUN (back-to-back), else go to IDLE.
REQ-020 Latency: from the edge sampling start to done high SHALL be WIDTH/DIGIT+1 edges.
REQ-021 start and operand changes while busy=1 SHALL be ignored; the operation continues on the captured values.
REQ-022 sum, c_out and overflow SHALL hold their last result until the next DONE entry; mid-operation values are never visible on them.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; c_out is the carry out of bit WIDTH-1.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, busy=0, done=0, sum=0, c_out=0, overflow=0, and clear the shift registers, carry and step count.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after deassertion behaves as from power-up.

Configuration
REQ-026 Macro ADD_SUB_OVERFLOW_EN SHALL control signed overflow detection.
REQ-027 With ADD_SUB_OVERFLOW_EN defined: overflow = carry into MSB XOR carry out of MSB, registered with sum.
REQ-028 Without ADD_SUB_OVERFLOW_EN: the overflow port remains, tied to constant 0, and no detection logic is present.

Verification
REQ-029 WIDTH=8, DIGIT=1: a=0x02, b=0x03, c_in=0 -> done 9 edges after start, sum=0x05, c_out=0, overflow=0.
REQ-030 a=0x02, b=0x03, c_in=1 -> sum=0xFF, c_out=0 (borrow); a=0x03, b=0x02, c_in=1 -> sum=0x01, c_out=1.
REQ-031 a=0x7F, b=0x01, c_in=0 -> sum=0x80, overflow=1 with macro, 0 without; a=0xFF, b=0x01 -> sum=0x00, c_out=1, overflow=0.
REQ-032 start pulsed and a/b changed on the 3rd RUN cycle -> ignored, result matches the original operands; start held in DONE -> next RUN begins with no IDLE cycle.
REQ-033 rst asserted on the 4th RUN cycle -> outputs zero immediately, no done pulse; a fresh 0x10+0x20 -> sum=0x30.
REQ-034 WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001, c_in=0 -> done 5 edges after start, sum=0x0000, c_out=1.

Source files
------------

// File: rtl/add_sub_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, result registered on completion.
// Optional signed overflow detection when ADD_SUB_OVERFLOW_EN is defined.
module add_sub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    step;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] acc_next;
  logic             last_step;

  // Each digit of partial result enters at the MSB end, so after STEPS shifts acc is aligned.
  always_comb begin
    dsum      = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    acc_next  = (acc >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    last_step = (step == CW'(STEPS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      step  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b ^ {WIDTH{c_in}};
            acc   <= '0;
            carry <= c_in;
            step  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          acc   <= acc_next;
          carry <= dsum[DIGIT];
          step  <= step + CW'(1);
          if (last_step) begin
            sum   <= acc_next;
            c_out <= dsum[DIGIT];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ADD_SUB_OVERFLOW_EN
  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  logic msb_cin;
  assign msb_cin = dsum[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow <= 1'b0;
    else if (state == RUN && last_step)
      overflow <= msb_cin ^ dsum[DIGIT];
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_add_sub_serial.sv
// Randomized self-checking bench for add_sub_serial (8x1 and 16x4 instances)
// against an integer-arithmetic reference model.
module tb_add_sub_serial;

`ifdef ADD_SUB_OVERFLOW_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ov8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ov16;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;

  logic [63:0] p_sum8, p_sum16, last_sum8, last_sum16;
  bit          p_c8, p_v8, p_c16, p_v16;

  always #5 clk = ~clk;

  add_sub_serial #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .overflow(ov8)
  );

  add_sub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .c_in(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .c_out(cout16), .overflow(ov16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned modulo sum plus carry, and signed overflow from true signed range.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input bit cin, output logic [63:0] s, output bit co,
                                output bit v);
    logic [63:0] mask, full;
    longint      sa, sb, r, lim;
    mask = (64'd1 << w) - 64'd1;
    full = cin ? ((a & mask) + ((~b) & mask) + 64'd1) : ((a & mask) + (b & mask));
    s    = full & mask;
    co   = full[w];
    lim  = longint'(1) << (w - 1);
    sa   = a[w-1] ? longint'(a & mask) - (lim * 2) : longint'(a & mask);
    sb   = b[w-1] ? longint'(b & mask) - (lim * 2) : longint'(b & mask);
    r    = cin ? sa - sb : sa + sb;
    v    = OV_EN && ((r > lim - 1) || (r < -lim));
  endfunction

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input bit cin);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = cin;
    model(8, 64'(a), 64'(b), cin, p_sum8, p_c8, p_v8);
  endtask

  // Called at the negedge where start8 was driven; optionally disturbs inputs while busy
  // or chains a new operation in the DONE cycle.
  task automatic await8(input string tag, input bit scramble, input bit chain);
    int edges;
    @(posedge clk); edges = 1;
    @(negedge clk); start8 = 1'b0;
    check({tag, "_busy"}, 64'(busy8), 64'd1);
    check({tag, "_hold"}, 64'(sum8), last_sum8);
    while (!done8 && edges < 40) begin
      start8 = scramble && (edges == 3);
      if (scramble) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      @(posedge clk); edges++;
      @(negedge clk); start8 = 1'b0;
    end
    check({tag, "_lat"}, 64'(edges), 64'd9);
    check({tag, "_sum"}, 64'(sum8), p_sum8);
    check({tag, "_cout"}, 64'(cout8), 64'(p_c8));
    check({tag, "_ovf"}, 64'(ov8), 64'(p_v8));
    check({tag, "_bsy0"}, 64'(busy8), 64'd0);
    last_sum8 = p_sum8;
    if (chain) begin
      launch8(8'($urandom), 8'($urandom), 1'($urandom));
    end else begin
      @(negedge clk);
      check({tag, "_pulse"}, 64'({done8, busy8}), 64'd0);
    end
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input bit cin);
    int edges;
    @(negedge clk);
    start16 = 1'b1; a16 = a; b16 = b; cin16 = cin;
    model(16, 64'(a), 64'(b), cin, p_sum16, p_c16, p_v16);
    @(posedge clk); edges = 1;
    @(negedge clk); start16 = 1'b0;
    check({tag, "_hold"}, 64'(sum16), last_sum16);
    while (!done16 && edges < 40) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 64'(edges), 64'd5);
    check({tag, "_sum"}, 64'(sum16), p_sum16);
    check({tag, "_cout"}, 64'(cout16), 64'(p_c16));
    check({tag, "_ovf"}, 64'(ov16), 64'(p_v16));
    last_sum16 = p_sum16;
    @(negedge clk);
    check({tag, "_pulse"}, 64'(done16), 64'd0);
  endtask

  initial begin
    bit saw_done;
    last_sum8 = '0; last_sum16 = '0;
    @(negedge clk);
    check("rst_out8", 64'({busy8, done8, cout8, ov8, sum8}), 64'd0);
    check("rst_out16", 64'({busy16, done16, cout16, ov16, sum16}), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    launch8(8'h02, 8'h03, 1'b0); await8("add23", 0, 0);
    launch8(8'h02, 8'h03, 1'b1); await8("sub23", 0, 0);
    launch8(8'h7F, 8'h01, 1'b0); await8("ovf7f", 0, 0);
    launch8(8'hFF, 8'h01, 1'b0); await8("wrapff", 0, 0);
    launch8(8'h80, 8'h01, 1'b1); await8("subovf", 0, 0);
    launch8(8'h5A, 8'h33, 1'b0); await8("scramble", 1, 0);
    launch8(8'h12, 8'h34, 1'b1); await8("chain_a", 0, 1);
    await8("chain_b", 0, 0);
    launch8(8'h03, 8'h02, 1'b1); await8("sub32", 0, 0);

    // Abort in the 4th RUN cycle while outputs hold a nonzero result.
    launch8(8'h55, 8'h22, 1'b0);
    @(posedge clk);
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    check("abort_out", 64'({busy8, done8, cout8, ov8, sum8}), 64'd0);
    saw_done = 1'b0;
    repeat (3) begin @(negedge clk); saw_done |= done8; end
    rst = 1'b0;
    repeat (12) begin @(negedge clk); saw_done |= done8; end
    check("abort_nodone", 64'(saw_done), 64'd0);
    last_sum8 = '0; last_sum16 = '0;
    launch8(8'h10, 8'h20, 1'b0); await8("fresh", 0, 0);

    run16("w16_ffff", 16'hFFFF, 16'h0001, 1'b0);
    run16("w16_sub", 16'h1234, 16'h4321, 1'b1);
    run16("w16_ovf", 16'h7FFF, 16'h0001, 1'b0);

    for (int i = 0; i < 20; i++) begin
      launch8(8'($urandom), 8'($urandom), 1'($urandom));
      await8("rnd8", (i % 5) == 2, (i % 7) == 3);
      if ((i % 7) == 3) await8("rnd8_chain", 0, 0);
    end
    for (int i = 0; i < 8; i++)
      run16("rnd16", 16'($urandom), 16'($urandom), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
